// File: rtl/brisc_pkg.sv
// Shared types for the brisc pipeline: register index width, datapath
// select enums, exception codes and the hazard controller state encoding.
package brisc_pkg;

    localparam int REG_BITS = 5;

    typedef enum logic [1:0] {
        NO_FWD     = 2'd0,
        FROM_CACHE = 2'd1,
        FROM_WB    = 2'd2
    } fwd_src_e;

    typedef enum logic {
        PC_PLUS4  = 1'b0,
        PC_TARGET = 1'b1
    } pc_src_e;

    typedef enum logic [2:0] {
        NO_XCPT       = 3'd0,
        MEM_UNALIGNED = 3'd1,
        ILLEGAL_INSTR = 3'd2,
        ECALL         = 3'd3,
        BREAKPOINT    = 3'd4
    } xcpt_e;

    // Writeback result source of the instruction in E; RES_CACHE marks a load.
    typedef enum logic [1:0] {
        RES_ALU   = 2'd0,
        RES_CACHE = 2'd1,
        RES_PC4   = 2'd2
    } result_src_e;

    typedef enum logic [1:0] {
        H_RUN   = 2'd0,
        H_DMISS = 2'd1,
        H_IMISS = 2'd2,
        H_XCPT  = 2'd3
    } hz_state_e;

    // True when a writing stage produces the register being read; x0 never matches.
    function automatic logic fwd_hit(input logic                wr,
                                     input logic [REG_BITS-1:0] rd,
                                     input logic [REG_BITS-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one ALU source operand. The cache stage holds the
// younger result, so it wins over writeback when both target the same register.
module fwd_unit
    import brisc_pkg::*;
(
    input  logic [REG_BITS-1:0] i_rs,
    input  logic [REG_BITS-1:0] i_rd_C,
    input  logic                i_reg_write_C,
    input  logic [REG_BITS-1:0] i_rd_WB,
    input  logic                i_reg_write_WB,
    output fwd_src_e            o_fwd
);

    // Pick the youngest in-flight producer of i_rs.
    always_comb begin
        o_fwd = NO_FWD;
        if (fwd_hit(i_reg_write_C, i_rd_C, i_rs)) begin
            o_fwd = FROM_CACHE;
        end else if (fwd_hit(i_reg_write_WB, i_rd_WB, i_rs)) begin
            o_fwd = FROM_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch
// handling, and an FSM sequencing D$ misses, I$ misses and exception drain.
// All control outputs are forced inactive while reset is held.
module hazard_ctrl
    import brisc_pkg::*;
#(
    parameter int XCPT_DRAIN = 2,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_BITS-1:0] i_rs1_D,
    input  logic [REG_BITS-1:0] i_rs2_D,
    input  logic [REG_BITS-1:0] i_rs1_E,
    input  logic [REG_BITS-1:0] i_rs2_E,
    input  logic [REG_BITS-1:0] i_rd_E,
    input  result_src_e         i_result_src_E,
    input  logic [REG_BITS-1:0] i_rd_C,
    input  logic [REG_BITS-1:0] i_rd_WB,
    input  logic                i_reg_write_C,
    input  logic                i_reg_write_WB,
    input  pc_src_e             i_pc_src_E,
    input  xcpt_e               i_xcpt_E,
    input  logic                i_imiss_F,
    input  logic                i_iready,
    input  logic                i_dmiss_C,
    input  logic                i_dready,
    output fwd_src_e            o_fwd_src1_E,
    output fwd_src_e            o_fwd_src2_E,
    output logic                o_stall_F,
    output logic                o_stall_D,
    output logic                o_stall_E,
    output logic                o_stall_C,
    output logic                o_flush_D,
    output logic                o_flush_E,
    output logic                o_flush_C,
    output logic                o_flush_WB,
    output logic                o_xcpt_redirect,
    output logic [CNT_W-1:0]    o_stall_cnt
);

    // Drain counter holds XCPT_DRAIN-1 down to 0, one H_XCPT cycle per value.
    localparam int DRAIN_W = (XCPT_DRAIN > 1) ? $clog2(XCPT_DRAIN) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(XCPT_DRAIN - 1);

    hz_state_e          r_state, w_next_state;
    logic [DRAIN_W-1:0] r_drain, w_drain_next;
    logic               r_xcpt_pend, w_xcpt_pend_next;
    logic [CNT_W-1:0]   r_stall_cnt;

    fwd_src_e w_fwd1, w_fwd2;
    logic     w_xcpt, w_branch, w_load_use;
    logic     w_stall_F, w_stall_D, w_stall_E, w_stall_C;
    logic     w_flush_D, w_flush_E, w_flush_C, w_flush_WB, w_redirect;

    fwd_unit u_fwd1 (
        .i_rs           (i_rs1_E),
        .i_rd_C         (i_rd_C),
        .i_reg_write_C  (i_reg_write_C),
        .i_rd_WB        (i_rd_WB),
        .i_reg_write_WB (i_reg_write_WB),
        .o_fwd          (w_fwd1)
    );

    fwd_unit u_fwd2 (
        .i_rs           (i_rs2_E),
        .i_rd_C         (i_rd_C),
        .i_reg_write_C  (i_reg_write_C),
        .i_rd_WB        (i_rd_WB),
        .i_reg_write_WB (i_reg_write_WB),
        .o_fwd          (w_fwd2)
    );

    assign w_xcpt     = (i_xcpt_E != NO_XCPT);
    assign w_branch   = (i_pc_src_E == PC_TARGET);
    assign w_load_use = (i_result_src_E == RES_CACHE) && (i_rd_E != '0) &&
                        ((i_rd_E == i_rs1_D) || (i_rd_E == i_rs2_D));

    // Next-state and stage control; events are resolved in fixed priority order
    // dmiss > exception (live or held from a D$ miss) > branch > load-use > imiss.
    always_comb begin
        w_next_state     = r_state;
        w_drain_next     = r_drain;
        w_xcpt_pend_next = r_xcpt_pend;
        w_stall_F  = 1'b0;
        w_stall_D  = 1'b0;
        w_stall_E  = 1'b0;
        w_stall_C  = 1'b0;
        w_flush_D  = 1'b0;
        w_flush_E  = 1'b0;
        w_flush_C  = 1'b0;
        w_flush_WB = 1'b0;
        w_redirect = 1'b0;
        case (r_state)
            H_RUN, H_IMISS: begin
                if (i_dmiss_C) begin
                    // Freeze everything up to C; an exception in E waits for the fill.
                    w_stall_F        = 1'b1;
                    w_stall_D        = 1'b1;
                    w_stall_E        = 1'b1;
                    w_stall_C        = 1'b1;
                    w_flush_WB       = 1'b1;
                    w_xcpt_pend_next = r_xcpt_pend | w_xcpt;
                    w_next_state     = H_DMISS;
                end else if (w_xcpt || r_xcpt_pend) begin
                    // Squash the faulting op before it reaches the cache.
                    w_flush_D        = 1'b1;
                    w_flush_E        = 1'b1;
                    w_flush_C        = 1'b1;
                    w_redirect       = 1'b1;
                    w_xcpt_pend_next = 1'b0;
                    w_drain_next     = DRAIN_LOAD;
                    w_next_state     = H_XCPT;
                end else if (r_state == H_IMISS) begin
                    if (i_iready) begin
                        w_next_state = H_RUN;
                    end else begin
                        w_stall_F = 1'b1;
                        w_flush_D = 1'b1;
                    end
                    if (w_branch) begin
                        w_flush_D = 1'b1;
                        w_flush_E = 1'b1;
                    end
                end else if (w_branch) begin
                    w_flush_D = 1'b1;
                    w_flush_E = 1'b1;
                end else if (w_load_use) begin
                    w_stall_F = 1'b1;
                    w_stall_D = 1'b1;
                    w_flush_E = 1'b1;
                end else if (i_imiss_F) begin
                    w_stall_F    = 1'b1;
                    w_flush_D    = 1'b1;
                    w_next_state = H_IMISS;
                end
            end
            H_DMISS: begin
                w_xcpt_pend_next = r_xcpt_pend | w_xcpt;
                if (i_dready) begin
                    w_next_state = H_RUN;
                end else begin
                    w_stall_F  = 1'b1;
                    w_stall_D  = 1'b1;
                    w_stall_E  = 1'b1;
                    w_stall_C  = 1'b1;
                    w_flush_WB = 1'b1;
                end
            end
            H_XCPT: begin
                w_stall_F = 1'b1;
                w_flush_D = 1'b1;
                if (r_drain == '0) begin
                    w_next_state = H_RUN;
                end else begin
                    w_drain_next = r_drain - DRAIN_W'(1);
                end
            end
            default: begin
                w_next_state = H_RUN;
            end
        endcase
    end

    // FSM state, drain counter and held-exception flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= H_RUN;
            r_drain     <= '0;
            r_xcpt_pend <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain     <= w_drain_next;
            r_xcpt_pend <= w_xcpt_pend_next;
        end
    end

    // Performance counter of fetch-stall cycles; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_F) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_fwd_src1_E    = reset ? NO_FWD : w_fwd1;
    assign o_fwd_src2_E    = reset ? NO_FWD : w_fwd2;
    assign o_stall_F       = w_stall_F  & ~reset;
    assign o_stall_D       = w_stall_D  & ~reset;
    assign o_stall_E       = w_stall_E  & ~reset;
    assign o_stall_C       = w_stall_C  & ~reset;
    assign o_flush_D       = w_flush_D  & ~reset;
    assign o_flush_E       = w_flush_E  & ~reset;
    assign o_flush_C       = w_flush_C  & ~reset;
    assign o_flush_WB      = w_flush_WB & ~reset;
    assign o_xcpt_redirect = w_redirect & ~reset;
    assign o_stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a cycle-by-cycle reference model and
// hand-computed literal expectations at the key points of each scenario.
module tb_hazard_ctrl;
    import brisc_pkg::*;

    localparam int XD = 2;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;
    logic [REG_BITS-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_C, rd_WB;
    result_src_e result_src_E;
    logic reg_write_C, reg_write_WB;
    pc_src_e pc_src_E;
    xcpt_e xcpt_E;
    logic imiss_F, iready, dmiss_C, dready;
    fwd_src_e fwd1, fwd2;
    logic sF, sD, sE, sC, fD, fE, fC, fWB, redir;
    logic [CW-1:0] scnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    bit m_dmiss = 0, m_imiss = 0, m_pend = 0;
    int m_drain = 0;
    logic [CW-1:0] m_cnt = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(.XCPT_DRAIN(XD), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .i_rs1_D(rs1_D), .i_rs2_D(rs2_D), .i_rs1_E(rs1_E), .i_rs2_E(rs2_E),
        .i_rd_E(rd_E), .i_result_src_E(result_src_E), .i_rd_C(rd_C), .i_rd_WB(rd_WB),
        .i_reg_write_C(reg_write_C), .i_reg_write_WB(reg_write_WB),
        .i_pc_src_E(pc_src_E), .i_xcpt_E(xcpt_E),
        .i_imiss_F(imiss_F), .i_iready(iready), .i_dmiss_C(dmiss_C), .i_dready(dready),
        .o_fwd_src1_E(fwd1), .o_fwd_src2_E(fwd2),
        .o_stall_F(sF), .o_stall_D(sD), .o_stall_E(sE), .o_stall_C(sC),
        .o_flush_D(fD), .o_flush_E(fE), .o_flush_C(fC), .o_flush_WB(fWB),
        .o_xcpt_redirect(redir), .o_stall_cnt(scnt)
    );

    function automatic fwd_src_e fwd_expect(input logic [REG_BITS-1:0] rs);
        if (reg_write_C && rd_C != 0 && rd_C == rs) return FROM_CACHE;
        if (reg_write_WB && rd_WB != 0 && rd_WB == rs) return FROM_WB;
        return NO_FWD;
    endfunction

    task automatic idle();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_C = 0; rd_WB = 0;
        result_src_E = RES_ALU; reg_write_C = 0; reg_write_WB = 0;
        pc_src_E = PC_PLUS4; xcpt_E = NO_XCPT;
        imiss_F = 0; iready = 0; dmiss_C = 0; dready = 0;
    endtask

    // Compare every output against the model at the falling edge, then advance the model.
    task automatic chk();
        bit eF, eD, eE, eC, efD, efE, efC, efWB, erd, ev_x, ev_b, ev_lu;
        fwd_src_e ef1, ef2;
        logic [12:0] exp_v, act_v;
        @(negedge clk);
        cyc++;
        {eF, eD, eE, eC, efD, efE, efC, efWB, erd} = '0;
        ef1 = NO_FWD;
        ef2 = NO_FWD;
        if (!reset) begin
            ef1   = fwd_expect(rs1_E);
            ef2   = fwd_expect(rs2_E);
            ev_x  = (xcpt_E != NO_XCPT);
            ev_b  = (pc_src_E == PC_TARGET);
            ev_lu = (result_src_E == RES_CACHE) && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
            if (m_dmiss) begin
                if (ev_x) m_pend = 1;
                if (dready) m_dmiss = 0;
                else {eF, eD, eE, eC, efWB} = 5'b11111;
            end else if (m_drain > 0) begin
                eF = 1; efD = 1; m_drain--;
            end else if (dmiss_C) begin
                {eF, eD, eE, eC, efWB} = 5'b11111;
                m_dmiss = 1; m_imiss = 0;
                if (ev_x) m_pend = 1;
            end else if (ev_x || m_pend) begin
                efD = 1; efE = 1; efC = 1; erd = 1;
                m_drain = XD; m_pend = 0; m_imiss = 0;
            end else if (m_imiss) begin
                if (iready) m_imiss = 0;
                else begin eF = 1; efD = 1; end
                if (ev_b) begin efD = 1; efE = 1; end
            end else if (ev_b) begin
                efD = 1; efE = 1;
            end else if (ev_lu) begin
                eF = 1; eD = 1; efE = 1;
            end else if (imiss_F) begin
                eF = 1; efD = 1; m_imiss = 1;
            end
        end
        exp_v = {ef1, ef2, eF, eD, eE, eC, efD, efE, efC, efWB, erd};
        act_v = {fwd1, fwd2, sF, sD, sE, sC, fD, fE, fC, fWB, redir};
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL ctl cycle %0d: actual=%b required=%b", cyc, act_v, exp_v);
        end
        total++;
        if (scnt !== m_cnt) begin
            bad++;
            $display("FAIL stall_cnt cycle %0d: actual=%0d required=%0d", cyc, scnt, m_cnt);
        end
        if (reset) begin
            m_cnt = '0; m_dmiss = 0; m_imiss = 0; m_pend = 0; m_drain = 0;
        end else if (eF) begin
            m_cnt = m_cnt + CW'(1);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            chk();
            adv();
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        chk();
        adv();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        @(posedge clk);
        #1;

        // 1. forwarding priority and x0
        do_reset();
        rd_C = 5; reg_write_C = 1; rd_WB = 5; reg_write_WB = 1; rs1_E = 5;
        chk(); lit("fwd_cache", 32'(fwd1), 32'(FROM_CACHE)); adv();
        rd_C = 0;
        chk(); lit("fwd_wb", 32'(fwd1), 32'(FROM_WB)); adv();
        rs1_E = 0;
        chk(); lit("fwd_x0", 32'(fwd1), 32'(NO_FWD)); adv();
        rs2_E = 9; rd_WB = 9; reg_write_WB = 0; rd_C = 9; reg_write_C = 1;
        chk(); lit("fwd2_cache", 32'(fwd2), 32'(FROM_CACHE)); adv();
        reg_write_C = 0;
        run(1);
        idle();

        // 2. load-use stall
        do_reset();
        result_src_E = RES_CACHE; rd_E = 7; rs2_D = 7;
        chk(); lit("lu_stall", 32'({sF, sD, fE}), 7); adv();
        result_src_E = RES_ALU; rd_E = 0;
        chk(); lit("lu_release", 32'({sF, sD, fE}), 0); lit("lu_cnt", 32'(scnt), 1); adv();
        result_src_E = RES_CACHE; rd_E = 0; rs1_D = 0;
        run(1);
        // branch beats load-use
        rd_E = 3; rs1_D = 3; pc_src_E = PC_TARGET;
        chk(); lit("br_over_lu", 32'({sF, sD, fD, fE}), 3); adv();
        idle();

        // 3. D$ miss for 4 cycles
        do_reset();
        dmiss_C = 1;
        for (int i = 0; i < 4; i++) begin
            chk(); lit("dmiss_hold", 32'({sF, sD, sE, sC, fWB}), 31); adv();
        end
        dmiss_C = 0; dready = 1;
        chk(); lit("dready_rel", 32'({sF, sD, sE, sC, fWB}), 0); adv();
        dready = 0;
        chk(); lit("dmiss_cnt", 32'(scnt), 4); adv();

        // 4. exception with drain
        do_reset();
        xcpt_E = MEM_UNALIGNED;
        chk(); lit("xcpt_entry", 32'({sF, fD, fE, fC, redir}), 15); adv();
        chk(); lit("xcpt_drain1", 32'({sF, fD, redir}), 6); adv();
        xcpt_E = NO_XCPT;
        chk(); lit("xcpt_drain2", 32'({sF, fD, redir}), 6); adv();
        chk(); lit("xcpt_done", 32'({sF, fD, redir}), 0); lit("xcpt_cnt", 32'(scnt), 2); adv();

        // 5. dmiss and exception together
        do_reset();
        dmiss_C = 1; xcpt_E = ILLEGAL_INSTR;
        chk(); lit("dx_first", 32'({sF, redir}), 2); adv();
        run(2);
        dmiss_C = 0; dready = 1;
        chk(); lit("dx_dready", 32'(redir), 0); adv();
        dready = 0; xcpt_E = NO_XCPT;
        chk(); lit("dx_redirect", 32'({fD, fE, fC, redir}), 15); adv();
        run(3);

        // 6. I$ miss, branch mid-miss, reset mid-miss
        do_reset();
        imiss_F = 1;
        chk(); lit("imiss_entry", 32'({sF, fD}), 3); adv();
        run(1);
        pc_src_E = PC_TARGET;
        chk(); lit("imiss_branch", 32'({sF, fD, fE}), 7); adv();
        pc_src_E = PC_PLUS4;
        chk(); lit("imiss_hold", 32'({sF, fD, fE}), 6); adv();
        reset = 1;
        chk(); lit("reset_mid", 32'({sF, sD, sE, sC, fD, fE, fC, fWB, redir}), 0); adv();
        reset = 0; imiss_F = 0;
        chk(); lit("post_reset", 32'({sF, fD, scnt}), 0); adv();
        imiss_F = 1;
        run(2);
        imiss_F = 0; iready = 1;
        chk(); lit("iready_rel", 32'(sF), 0); adv();
        iready = 0;
        run(1);

        // I$ miss preempted by D$ miss, then re-detected
        do_reset();
        imiss_F = 1;
        run(1);
        dmiss_C = 1;
        chk(); lit("imiss_to_dmiss", 32'({sC, fWB}), 3); adv();
        dmiss_C = 0; dready = 1;
        run(1);
        dready = 0;
        chk(); lit("imiss_redetect", 32'({sF, fD}), 3); adv();
        imiss_F = 0; iready = 1;
        run(1);
        iready = 0;
        run(1);

        // stall counter wrap
        do_reset();
        dmiss_C = 1;
        run(300);
        dmiss_C = 0; dready = 1;
        run(1);
        dready = 0;
        chk(); lit("cnt_wrap", 32'(scnt), 300 % 256); adv();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
